bitfield_move_unit: RTL and testbench

//  Pipelined Tomasulo execution unit for the A64 bitfield-move family: UBFM (extract, zero-ext),

---
 rtl/bfm_pkg.sv | 51 +++++
 rtl/bitfield_move_unit_if.sv | 29 ++
 rtl/bfm_datapath.sv | 35 +++
 rtl/bitfield_move_unit.sv | 78 +++++++
 tb/tb_bitfield_move_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bfm_pkg.sv
// Shared types and mask helpers for the A64 bitfield-move execution unit.
// The masks follow the DecodeBitMasks construction with N=1 (64-bit operands only).
package bfm_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    BFM_UBFM = 2'd0,
    BFM_SBFM = 2'd1,
    BFM_BFM  = 2'd2
  } bfm_op_t;

  typedef struct packed {
    bfm_op_t           op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_d;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] tmask;
    logic [5:0]        immr;
    logic [5:0]        imms;
  } s1_payload_t;

  typedef struct packed {
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] tmask;
  } bit_masks_t;

  function automatic logic [DATA_W-1:0] ror64(input logic [DATA_W-1:0] x, input logic [5:0] r);
    logic [2*DATA_W-1:0] xx;
    xx = {x, x} >> r;
    return xx[DATA_W-1:0];
  endfunction

  // n is 1..64; a count of 64 must give all-ones rather than wrapping to zero.
  function automatic logic [DATA_W-1:0] ones(input logic [6:0] n);
    if (n[6]) return '1;
    return (64'd1 << n[5:0]) - 64'd1;
  endfunction

  function automatic bit_masks_t decode_bit_masks(input logic [5:0] immr, input logic [5:0] imms);
    bit_masks_t m;
    logic [5:0] d;
    d       = imms - immr;
    m.wmask = ror64(ones({1'b0, imms} + 7'd1), immr);
    m.tmask = ones({1'b0, d} + 7'd1);
    return m;
  endfunction

endpackage

// File: rtl/bitfield_move_unit_if.sv
// Issue-side and CDB-side signals of the bitfield-move unit.
// master = reservation station / CDB side, slave = the execution unit.
interface bitfield_move_unit_if;
  import bfm_pkg::*;

  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  bfm_op_t           i_op;
  logic [TAG_W-1:0]  i_tag;
  logic [DATA_W-1:0] i_val_a;
  logic [DATA_W-1:0] i_val_d;
  logic [5:0]        i_immr;
  logic [5:0]        i_imms;
  logic              o_valid;
  logic              i_cdb_gnt;
  logic [TAG_W-1:0]  o_tag;
  logic [DATA_W-1:0] o_res;

  modport master (
    output i_flush, i_valid, i_op, i_tag, i_val_a, i_val_d, i_immr, i_imms, i_cdb_gnt,
    input  o_ready, o_valid, o_tag, o_res
  );

  modport slave (
    input  i_flush, i_valid, i_op, i_tag, i_val_a, i_val_d, i_immr, i_imms, i_cdb_gnt,
    output o_ready, o_valid, o_tag, o_res
  );
endinterface

// File: rtl/bfm_datapath.sv
// Combinational mask-apply stage: turns a latched S1 payload into the broadcast result.
module bfm_datapath
  import bfm_pkg::*;
(
  input  s1_payload_t       p,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] res
);

  logic [DATA_W-1:0] rot;
  logic [DATA_W-1:0] top;
  logic [DATA_W-1:0] bot;

  assign tag = p.tag;

  always_comb begin
    rot = ror64(p.val_a, p.immr);
    top = '0;
    bot = rot & p.wmask;
    res = bot & p.tmask;
    case (p.op)
      BFM_SBFM: begin
        top = {DATA_W{p.val_a[p.imms]}};
        res = (top & ~p.tmask) | (bot & p.tmask);
      end
      BFM_BFM: begin
        bot = (p.val_d & ~p.wmask) | (rot & p.wmask);
        res = (p.val_d & ~p.tmask) | (bot & p.tmask);
      end
      // Reserved encoding 3 falls through to UBFM.
      default: res = bot & p.tmask;
    endcase
  end

endmodule

// File: rtl/bitfield_move_unit.sv
// Two-stage Tomasulo execution unit for UBFM/SBFM/BFM, tag carried through to the CDB.
// S1 holds operands plus decoded masks; S2 holds the result presented on o_*.
module bitfield_move_unit
  import bfm_pkg::*;
(
  input logic               clk,
  input logic               rst,
  bitfield_move_unit_if.slave bus
);

  // valid/ready: a transfer happens on a cycle where valid & ready (issue) or
  // o_valid & i_cdb_gnt (broadcast); once raised, o_valid and its payload hold
  // until granted, and valid never depends combinationally on ready.
  logic              s1_valid;
  logic              o_valid_q;
  logic              s2_adv;
  logic              ready;
  s1_payload_t       s1_q;
  s1_payload_t       s1_d;
  bit_masks_t        masks;
  logic [TAG_W-1:0]  o_tag_q;
  logic [DATA_W-1:0] o_res_q;
  logic [TAG_W-1:0]  s2_tag;
  logic [DATA_W-1:0] s2_res;

  assign s2_adv = !o_valid_q || bus.i_cdb_gnt;
  assign ready  = !s1_valid || s2_adv;
  assign masks  = decode_bit_masks(bus.i_immr, bus.i_imms);

  always_comb begin
    s1_d = '{op:    bus.i_op,
             tag:   bus.i_tag,
             val_a: bus.i_val_a,
             val_d: bus.i_val_d,
             wmask: masks.wmask,
             tmask: masks.tmask,
             immr:  bus.i_immr,
             imms:  bus.i_imms};
  end

  bfm_datapath u_datapath (
    .p   (s1_q),
    .tag (s2_tag),
    .res (s2_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      o_valid_q <= 1'b0;
      o_tag_q   <= '0;
      o_res_q   <= '0;
    end else if (bus.i_flush) begin
      // Squash beats both a pending grant and a same-cycle issue.
      s1_valid  <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      if (s2_adv) begin
        o_valid_q <= s1_valid;
        if (s1_valid) begin
          o_tag_q <= s2_tag;
          o_res_q <= s2_res;
        end
      end
      if (ready) begin
        s1_valid <= bus.i_valid;
        if (bus.i_valid) s1_q <= s1_d;
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = o_valid_q;
  assign bus.o_tag   = o_tag_q;
  assign bus.o_res   = o_res_q;

endmodule

// File: tb/tb_bitfield_move_unit.sv
// Bench for bitfield_move_unit: directed cases plus randomized ops against a field-level model.
module tb_bitfield_move_unit;
  import bfm_pkg::*;

  localparam int EW = TAG_W + DATA_W;

  logic clk;
  logic rst;
  bitfield_move_unit_if bus();

  bitfield_move_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rx_count = 0;
  int gnt_mode = 0;  // 0 low, 1 high, 2 random
  logic [EW-1:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // Architectural bitfield move: pick the source field, place it, then fill.
  function automatic logic [63:0] ref_bfm(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] d, input int r, input int s);
    int w;
    int pos;
    logic [63:0] fm;
    logic [63:0] field;
    logic [63:0] res;
    if (s >= r) begin
      w = s - r + 1; pos = 0; field = a >> r;
    end else begin
      w = s + 1; pos = 64 - r; field = a;
    end
    fm    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    field = field & fm;
    case (op)
      2'd1: begin
        res = field << pos;
        if (a[s] && (pos + w) < 64) res = res | ({64{1'b1}} << (pos + w));
      end
      2'd2:    res = (d & ~(fm << pos)) | (field << pos);
      default: res = field << pos;
    endcase
    return res;
  endfunction

  // driver tasks
  task automatic gnt_driver();
    forever begin
      @(posedge clk);
      #2;
      case (gnt_mode)
        0:       bus.i_cdb_gnt = 1'b0;
        1:       bus.i_cdb_gnt = 1'b1;
        default: bus.i_cdb_gnt = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic issue_exp(input logic [1:0] op, input logic [5:0] tag, input logic [63:0] a,
                           input logic [63:0] d, input logic [5:0] r, input logic [5:0] s,
                           input logic [63:0] exp);
    int n;
    bus.i_valid = 1'b1;
    bus.i_op    = bfm_op_t'(op);
    bus.i_tag   = tag;
    bus.i_val_a = a;
    bus.i_val_d = d;
    bus.i_immr  = r;
    bus.i_imms  = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_ready && n < 200);
    if (!bus.o_ready) check("issue_timeout", {63'd0, bus.o_ready}, 64'd1);
    else exp_q.push_back({tag, exp});
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] tag, input logic [63:0] a,
                       input logic [63:0] d, input logic [5:0] r, input logic [5:0] s);
    issue_exp(op, tag, a, d, r, s, ref_bfm(op, a, d, int'(r), int'(s)));
  endtask

  task automatic issue_rand(input logic [5:0] tag);
    issue(2'($urandom_range(0, 3)), tag, {$urandom, $urandom}, {$urandom, $urandom},
          6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
  endtask

  // scoreboard
  task automatic monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst && bus.o_valid && bus.i_cdb_gnt && !bus.i_flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {63'd0, bus.o_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("res", bus.o_res, e[DATA_W-1:0]);
          check("tag", {58'd0, bus.o_tag}, {58'd0, e[EW-1:DATA_W]});
          rx_count++;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] held;
  logic [63:0] va;
  int          rx_base;

  initial begin
    bus.i_flush   = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_op      = BFM_UBFM;
    bus.i_tag     = '0;
    bus.i_val_a   = '0;
    bus.i_val_d   = '0;
    bus.i_immr    = '0;
    bus.i_imms    = '0;
    bus.i_cdb_gnt = 1'b0;
    rst = 1'b0;
    fork
      gnt_driver();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, bus.o_valid}, 64'd0);
    check("rst_tag", {58'd0, bus.o_tag}, 64'd0);
    check("rst_res", bus.o_res, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", {63'd0, bus.o_ready}, 64'd1);

    // UBFM extract with latency and tag echo
    gnt_mode = 1;
    @(posedge clk);
    #1;
    issue_exp(2'd0, 6'd5, 64'hFF, 64'd0, 6'd1, 6'd3, 64'h7);
    @(negedge clk);
    check("lat_cycle1", {63'd0, bus.o_valid}, 64'd0);
    @(negedge clk);
    check("lat_cycle2", {63'd0, bus.o_valid}, 64'd1);
    check("ubfm_res", bus.o_res, 64'h7);
    check("ubfm_tag", {58'd0, bus.o_tag}, 64'd5);
    wait_drain();

    // SXTB, BFI, full-width UBFM
    va = {$urandom, $urandom};
    issue_exp(2'd1, 6'd6, 64'h80, 64'd0, 6'd0, 6'd7, 64'hFFFF_FFFF_FFFF_FF80);
    issue_exp(2'd2, 6'd7, 64'hA, 64'hFFFF_FFFF, 6'd56, 6'd3, 64'hFFFF_FAFF);
    issue_exp(2'd0, 6'd8, va, 64'd0, 6'd0, 6'd63, va);
    issue_exp(2'd3, 6'd9, 64'hFF, 64'd0, 6'd1, 6'd3, 64'h7);
    wait_drain();

    // backpressure: no grant, pipe fills after two, then drains in order
    gnt_mode = 0;
    @(posedge clk);
    #1;
    rx_base = rx_count;
    fork
      begin
        for (int k = 0; k < 4; k++) issue_rand(6'(20 + k));
      end
      begin
        repeat (3) @(negedge clk);
        check("full_accepted", 64'(exp_q.size()), 64'd2);
        check("full_ready", {63'd0, bus.o_ready}, 64'd0);
        held = bus.o_res;
        repeat (4) begin
          @(negedge clk);
          check("hold_res", bus.o_res, held);
          check("hold_ready", {63'd0, bus.o_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        gnt_mode = 1;
      end
    join
    wait_drain();
    check("drain_count", 64'(rx_count - rx_base), 64'd4);

    // flush with both stages full plus a pending issue
    gnt_mode = 0;
    @(posedge clk);
    #1;
    issue_rand(6'd30);
    issue_rand(6'd31);
    bus.i_valid = 1'b1;
    bus.i_tag   = 6'd32;
    bus.i_flush = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_valid", {63'd0, bus.o_valid}, 64'd0);
    check("flush_ready", {63'd0, bus.o_ready}, 64'd1);
    gnt_mode = 1;
    // flush with an empty pipe must also drop the accepted-looking issue
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_quiet", {63'd0, bus.o_valid}, 64'd0);
    @(posedge clk);
    #1;

    // randomized stream with random grant
    gnt_mode = 2;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        issue_rand(6'(k));
      end
    end
    gnt_mode = 1;
    wait_drain();

    // asynchronous reset between edges discards in-flight ops
    gnt_mode = 0;
    @(posedge clk);
    #1;
    issue_rand(6'd40);
    issue_rand(6'd41);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_valid", {63'd0, bus.o_valid}, 64'd0);
    check("arst_res", bus.o_res, 64'd0);
    check("arst_tag", {58'd0, bus.o_tag}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", {63'd0, bus.o_ready}, 64'd1);
    gnt_mode = 1;
    @(posedge clk);
    #1;
    issue_exp(2'd0, 6'd9, 64'hFF, 64'd0, 6'd1, 6'd3, 64'h7);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
